// File: rtl/addr_reg_bank.sv
// rtl/addr_reg_bank.sv - 4-entry register bank addressed by a 2-bit sequencer
//
// Purpose: stores DataIn at the sequencer's current address {Address1,Address0},
// presents the registered word at that address, and tracks per-entry valid bits,
// fill status, sticky overwrite errors and address-step pulses.
//
// Ports:
//   Clock         in   1      system clock, all state on posedge
//   Reset         in   1      asynchronous active-low reset
//   Address1/0    in   1      sequencer address MSB/LSB
//   DataIn        in   WIDTH  write data
//   WriteEn       in   1      write DataIn to the addressed entry
//   Clear         in   1      synchronous clear of entries and flags, beats WriteEn
//   DataOut       out  WIDTH  registered word at current address (write-first bypass)
//   OutValid      out  1      addressed entry written since last clear
//   EntryValid    out  4      per-entry written flags
//   Full          out  1      all entries valid
//   Status        out  2      fill state: 00 EMPTY, 01 FILLING, 10 FULL
//   OverwriteErr  out  1      sticky: a write hit an already-valid entry
//   AddrStep      out  1      one-cycle pulse when the address changed

module addr_reg_bank #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Address1,
    input  logic             Address0,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             WriteEn,
    input  logic             Clear,
    output logic [WIDTH-1:0] DataOut,
    output logic             OutValid,
    output logic [3:0]       EntryValid,
    output logic             Full,
    output logic [1:0]       Status,
    output logic             OverwriteErr,
    output logic             AddrStep
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_FILLING = 2'b01,
        ST_FULL    = 2'b10,
        ST_UNUSED  = 2'b11
    } fill_state_t;

    fill_state_t      state;
    logic [WIDTH-1:0] mem [4];
    logic [1:0]       addr;
    logic [1:0]       addr_prev;
    logic [3:0]       valid_next;

    assign addr   = {Address1, Address0};
    assign Full   = &EntryValid;
    assign Status = state;

    // Next-cycle valid vector; both OutValid and the fill FSM look ahead with it
    always_comb begin
        valid_next = EntryValid;
        if (Clear) begin
            valid_next = 4'b0000;
        end else if (WriteEn) begin
            valid_next[addr] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            EntryValid   <= 4'b0000;
            DataOut      <= '0;
            OutValid     <= 1'b0;
            OverwriteErr <= 1'b0;
            AddrStep     <= 1'b0;
            addr_prev    <= 2'b00;
            state        <= ST_EMPTY;
        end else begin
            // Address tracking runs regardless of Clear
            addr_prev  <= addr;
            AddrStep   <= (addr != addr_prev);
            EntryValid <= valid_next;

            if (Clear) begin
                for (int i = 0; i < 4; i++) begin
                    mem[i] <= '0;
                end
                OverwriteErr <= 1'b0;
                DataOut      <= '0;
                OutValid     <= 1'b0;
            end else begin
                if (WriteEn) begin
                    mem[addr] <= DataIn;
                    if (EntryValid[addr]) begin
                        OverwriteErr <= 1'b1;
                    end
                end
                // Write-first: a same-cycle write is visible without waiting for mem
                DataOut  <= WriteEn ? DataIn : mem[addr];
                OutValid <= valid_next[addr];
            end

            case (state)
                ST_EMPTY: begin
                    if (!Clear && WriteEn) begin
                        state <= ST_FILLING;
                    end
                end
                ST_FILLING: begin
                    if (Clear) begin
                        state <= ST_EMPTY;
                    end else if (valid_next == 4'b1111) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (Clear) begin
                        state <= ST_EMPTY;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_reg_bank.sv
// tb/tb_addr_reg_bank.sv - directed self-checking bench for addr_reg_bank

module tb_addr_reg_bank;

    logic       Clock;
    logic       Reset;
    logic       Address1;
    logic       Address0;
    logic [3:0] DataIn;
    logic       WriteEn;
    logic       Clear;
    logic [3:0] DataOut;
    logic       OutValid;
    logic [3:0] EntryValid;
    logic       Full;
    logic [1:0] Status;
    logic       OverwriteErr;
    logic       AddrStep;

    int total;
    int bad;

    addr_reg_bank #(.WIDTH(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Address1    (Address1),
        .Address0    (Address0),
        .DataIn      (DataIn),
        .WriteEn     (WriteEn),
        .Clear       (Clear),
        .DataOut     (DataOut),
        .OutValid    (OutValid),
        .EntryValid  (EntryValid),
        .Full        (Full),
        .Status      (Status),
        .OverwriteErr(OverwriteErr),
        .AddrStep    (AddrStep)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs change 1 time unit after the edge, outputs sampled there too
    task automatic drive(input logic [1:0] a, input logic [3:0] d, input logic we, input logic clr);
        {Address1, Address0} = a;
        DataIn  = d;
        WriteEn = we;
        Clear   = clr;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        drive(2'b00, 4'h0, 1'b0, 1'b0);
        Reset = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        total++; if (DataOut !== 4'h0) begin bad++; $display("FAIL reset_dataout got=%h exp=0", DataOut); end
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
        total++; if (Status !== 2'b00) begin bad++; $display("FAIL reset_status got=%b exp=00", Status); end
        total++; if (Full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", Full); end
        total++; if (AddrStep !== 1'b0) begin bad++; $display("FAIL reset_addrstep got=%b exp=0", AddrStep); end
        total++; if (EntryValid !== 4'b0000 || OverwriteErr !== 1'b0) begin
            bad++; $display("FAIL reset_flags got ev=%b ovw=%b exp ev=0000 ovw=0", EntryValid, OverwriteErr);
        end
    endtask

    task automatic test_fill();
        drive(2'b00, 4'hA, 1'b1, 1'b0);
        tick();
        total++; if (DataOut !== 4'hA || OutValid !== 1'b1) begin
            bad++; $display("FAIL fill_bypass got=%h/%b exp=a/1", DataOut, OutValid);
        end
        total++; if (Status !== 2'b01 || EntryValid !== 4'b0001) begin
            bad++; $display("FAIL fill_first got st=%b ev=%b exp st=01 ev=0001", Status, EntryValid);
        end
        drive(2'b01, 4'hB, 1'b1, 1'b0);
        tick();
        total++; if (AddrStep !== 1'b1) begin bad++; $display("FAIL fill_step got=%b exp=1", AddrStep); end
        drive(2'b10, 4'hC, 1'b1, 1'b0);
        tick();
        total++; if (Status !== 2'b01 || Full !== 1'b0) begin
            bad++; $display("FAIL fill_three got st=%b full=%b exp st=01 full=0", Status, Full);
        end
        drive(2'b11, 4'hD, 1'b1, 1'b0);
        tick();
        total++; if (EntryValid !== 4'b1111 || Full !== 1'b1 || Status !== 2'b10) begin
            bad++; $display("FAIL fill_full got ev=%b full=%b st=%b exp 1111/1/10", EntryValid, Full, Status);
        end
        total++; if (OverwriteErr !== 1'b0) begin bad++; $display("FAIL fill_ovw got=%b exp=0", OverwriteErr); end
        drive(2'b10, 4'h0, 1'b0, 1'b0);
        tick();
        total++; if (DataOut !== 4'hC || OutValid !== 1'b1) begin
            bad++; $display("FAIL fill_readback got=%h/%b exp=c/1", DataOut, OutValid);
        end
        drive(2'b00, 4'h0, 1'b0, 1'b0);
        tick();
        total++; if (DataOut !== 4'hA) begin bad++; $display("FAIL fill_read0 got=%h exp=a", DataOut); end
    endtask

    task automatic test_overwrite();
        drive(2'b00, 4'h0, 1'b0, 1'b1);
        tick();
        total++; if (Status !== 2'b00 || EntryValid !== 4'b0000) begin
            bad++; $display("FAIL full_clear got st=%b ev=%b exp 00/0000", Status, EntryValid);
        end
        drive(2'b01, 4'h5, 1'b1, 1'b0);
        tick();
        total++; if (OverwriteErr !== 1'b0 || DataOut !== 4'h5) begin
            bad++; $display("FAIL ovw_first got ovw=%b do=%h exp 0/5", OverwriteErr, DataOut);
        end
        drive(2'b01, 4'h9, 1'b1, 1'b0);
        tick();
        total++; if (OverwriteErr !== 1'b1 || DataOut !== 4'h9) begin
            bad++; $display("FAIL ovw_second got ovw=%b do=%h exp 1/9", OverwriteErr, DataOut);
        end
        drive(2'b01, 4'h0, 1'b0, 1'b0);
        tick();
        total++; if (OverwriteErr !== 1'b1 || DataOut !== 4'h9 || Status !== 2'b01) begin
            bad++; $display("FAIL ovw_sticky got ovw=%b do=%h st=%b exp 1/9/01", OverwriteErr, DataOut, Status);
        end
    endtask

    task automatic test_clear_priority();
        drive(2'b11, 4'h7, 1'b1, 1'b0);
        tick();
        drive(2'b11, 4'hF, 1'b1, 1'b1);
        tick();
        total++; if (EntryValid !== 4'b0000 || Status !== 2'b00) begin
            bad++; $display("FAIL clr_flags got ev=%b st=%b exp 0000/00", EntryValid, Status);
        end
        total++; if (DataOut !== 4'h0 || OutValid !== 1'b0 || OverwriteErr !== 1'b0) begin
            bad++; $display("FAIL clr_out got do=%h ov=%b ovw=%b exp 0/0/0", DataOut, OutValid, OverwriteErr);
        end
        drive(2'b11, 4'h0, 1'b0, 1'b0);
        tick();
        total++; if (DataOut !== 4'h0 || OutValid !== 1'b0) begin
            bad++; $display("FAIL clr_nowrite got do=%h ov=%b exp 0/0", DataOut, OutValid);
        end
    endtask

    task automatic test_addr_step();
        logic [1:0] seq [5];
        logic       exp [5];
        seq = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
        exp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        drive(2'b00, 4'h0, 1'b0, 1'b0);
        tick();
        tick();
        total++; if (AddrStep !== 1'b0) begin bad++; $display("FAIL step_hold got=%b exp=0", AddrStep); end
        for (int i = 0; i < 5; i++) begin
            drive(seq[i], 4'h0, 1'b0, 1'b0);
            tick();
            total++; if (AddrStep !== exp[i]) begin
                bad++; $display("FAIL step_seq%0d got=%b exp=%b", i, AddrStep, exp[i]);
            end
        end
        tick();
        total++; if (AddrStep !== 1'b0) begin bad++; $display("FAIL step_settle got=%b exp=0", AddrStep); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(i[1:0], 4'h3, 1'b1, 1'b0);
            tick();
        end
        total++; if (Status !== 2'b10) begin bad++; $display("FAIL ar_prefull got=%b exp=10", Status); end
        drive(2'b10, 4'h6, 1'b1, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        total++; if (DataOut !== 4'h0 || OutValid !== 1'b0 || EntryValid !== 4'b0000 || Full !== 1'b0) begin
            bad++; $display("FAIL ar_data got do=%h ov=%b ev=%b full=%b exp 0/0/0000/0", DataOut, OutValid, EntryValid, Full);
        end
        total++; if (Status !== 2'b00 || OverwriteErr !== 1'b0 || AddrStep !== 1'b0) begin
            bad++; $display("FAIL ar_flags got st=%b ovw=%b stp=%b exp 00/0/0", Status, OverwriteErr, AddrStep);
        end
        tick();
        Reset = 1'b1;
        drive(2'b10, 4'h0, 1'b0, 1'b0);
        tick();
        total++; if (DataOut !== 4'h0 || OutValid !== 1'b0 || EntryValid !== 4'b0000) begin
            bad++; $display("FAIL ar_discard got do=%h ov=%b ev=%b exp 0/0/0000", DataOut, OutValid, EntryValid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_overwrite();
        test_clear_priority();
        test_addr_step();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
